// File: rtl/dac_output_dual.sv
// dac_output_dual: dual-channel DAC sample-pair buffer with primed, rate-divided playback
module dac_output_dual #(
   parameter int DATA_W      = 10,
   parameter int FIFO_DEPTH  = 8,
   parameter int PRIME_LEVEL = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [7:0]                    rate_div,
   input  logic [DATA_W-1:0]             ch1_data_in,
   input  logic [DATA_W-1:0]             ch2_data_in,
   input  logic                          data_valid,
   output logic                          data_ready,
   output logic [DATA_W-1:0]             dac_ch1_out,
   output logic [DATA_W-1:0]             dac_ch2_out,
   output logic                          dac_ch1_clk_out,
   output logic                          dac_ch2_clk_out,
   output logic                          dac_update,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] PRIME_LVL = (AW+1)'(PRIME_LEVEL);
   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
   state_t              r_state, w_state_nxt;
   logic [2*DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
   logic [AW:0]         r_level;
   logic [7:0]          r_div, r_rate;
   logic [DATA_W-1:0]   r_ch1, r_ch2;
   logic                r_update, r_underrun;
   logic                w_wr, w_tc, w_pop;
   assign data_ready      = rst_n && enable && (r_level < DEPTH);
   assign w_wr            = data_valid && data_ready;
   assign w_tc            = (r_state == RUN) && (r_div == r_rate);
   assign w_pop           = enable && w_tc && (r_level != '0);
   assign dac_ch1_out     = r_ch1;
   assign dac_ch2_out     = r_ch2;
   assign dac_ch1_clk_out = ~clk;
   assign dac_ch2_clk_out = ~clk;
   assign dac_update      = r_update;
   assign underrun        = r_underrun;
   assign fifo_level      = r_level;
   // next state: disable wins everywhere; an empty terminal count falls back to priming
   always_comb begin
      w_state_nxt = r_state;
      if (!enable) w_state_nxt = IDLE;
      else if (r_state == IDLE) w_state_nxt = PRIME;
      else if (r_state == PRIME && r_level >= PRIME_LVL) w_state_nxt = RUN;
      else if (w_tc && r_level == '0) w_state_nxt = PRIME;
   end
   // sample-pair storage; ch1 and ch2 live in one word so they can never skew
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= {ch1_data_in, ch2_data_in};
   end
   // control and datapath: flush on disable, divider only runs in RUN and reloads rate at 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_div      <= '0;
         r_rate     <= '0;
         r_ch1      <= MID;
         r_ch2      <= MID;
         r_update   <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_update <= w_pop;
         r_div    <= (r_state == RUN && !w_tc) ? r_div + 8'd1 : 8'd0;
         r_rate   <= (r_state != RUN || w_tc) ? rate_div : r_rate;
         if (!enable) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ch1      <= MID;
            r_ch2      <= MID;
            r_underrun <= 1'b0;
         end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_pop) {r_ch1, r_ch2} <= r_mem[r_rd_ptr];
            if (w_tc && r_level == '0) r_underrun <= 1'b1;
            r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
         end
      end
   end
endmodule
